serial2tcp_stream_tester: RTL and testbench

Self-checking stream endpoint for the serial2tcp path. It acts as the far end of the `serial2tcp_loopback` byte streams. It drives the loopback sink with a handshaked incrementing byte pattern and consumes the loopback source, comparing every returned byte against the expected pattern. It reports pass/fail, error counts and timeout status, and replaces free-running counter stimulus in bring-up and regression benches.

---
 rtl/serial2tcp_stream_tester.sv | 121 ++++++++++++
 tb/tb_serial2tcp_stream_tester.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial2tcp_stream_tester.sv
// Far-end tester for the serial2tcp loopback: drives an incrementing byte pattern out,
// checks the returned stream against the same pattern, and reports errors and timeouts.
module serial2tcp_stream_tester #(
  parameter int unsigned BURST_LEN = 256,
  parameter logic [7:0]  SEED      = 8'h00,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [15:0] rx_count
);

  localparam int unsigned   TimerW   = $clog2(TIMEOUT) + 1;
  localparam logic [16:0]   BurstLen = 17'(BURST_LEN);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       tx_sent_q, tx_sent_d;
  logic [15:0]       rx_count_q, rx_count_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              timeout_q, timeout_d;
  logic [TimerW-1:0] timer_q, timer_d;

  logic       tx_hs, rx_hs;
  logic [7:0] rx_expected;
  logic       rx_last;

  // Handshake-facing outputs depend only on state and counters.
  assign tx_valid = (state_q == StRun) && ({1'b0, tx_sent_q} < BurstLen);
  assign tx_data  = SEED + tx_sent_q[7:0];
  assign rx_ready = (state_q == StRun);

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign pass      = done && (err_count_q == 16'h0000) && !timeout_q;
  assign timeout   = timeout_q;
  assign err_count = err_count_q;
  assign rx_count  = rx_count_q;

  assign tx_hs       = tx_valid & tx_ready;
  assign rx_hs       = rx_valid & rx_ready;
  assign rx_expected = SEED + rx_count_q[7:0];
  assign rx_last     = (({1'b0, rx_count_q} + 17'd1) == BurstLen);

  always_comb begin
    state_d     = state_q;
    tx_sent_d   = tx_sent_q;
    rx_count_d  = rx_count_q;
    err_count_d = err_count_q;
    timeout_d   = timeout_q;
    timer_d     = timer_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          tx_sent_d   = 16'h0000;
          rx_count_d  = 16'h0000;
          err_count_d = 16'h0000;
          timeout_d   = 1'b0;
          timer_d     = '0;
        end
      end
      StRun: begin
        if (tx_hs) begin
          tx_sent_d = tx_sent_q + 16'd1;
        end
        if (rx_hs) begin
          rx_count_d = rx_count_q + 16'd1;
          timer_d    = '0;
          if ((rx_data != rx_expected) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
          end
          if (rx_last) begin
            state_d = StDone;
          end
        end else if (timer_q == TimerMax) begin
          // Abort: any TX beats not yet accepted are simply dropped.
          state_d   = StDone;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= StIdle;
      tx_sent_q   <= 16'h0000;
      rx_count_q  <= 16'h0000;
      err_count_q <= 16'h0000;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      tx_sent_q   <= tx_sent_d;
      rx_count_q  <= rx_count_d;
      err_count_q <= err_count_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
    end
  end

endmodule

// File: tb/tb_serial2tcp_stream_tester.sv
// Bench for serial2tcp_stream_tester: scenario table run through a queue-based loopback model,
// plus hand-written restart and mid-run reset sequences.
module tb_serial2tcp_stream_tester;

  localparam int unsigned BURST_LEN = 300;
  localparam logic [7:0]  SEED      = 8'hF0;
  localparam int unsigned TIMEOUT   = 1024;
  localparam int unsigned BUDGET    = 4000;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tx_valid, tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        rx_valid = 1'b0, rx_ready;
  logic [7:0]  rx_data = 8'h00;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count, rx_count;

  serial2tcp_stream_tester #(
    .BURST_LEN (BURST_LEN),
    .SEED      (SEED),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .err_count (err_count),
    .rx_count  (rx_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit          direct;     // tx wired straight to rx, no latency
    int unsigned tx_stall;   // percent of cycles with tx_ready low
    int unsigned rx_stall;   // percent of cycles with rx_valid withheld
    int          corrupt_a;  // rx beat index flipped by XOR 1, -1 for none
    int          corrupt_b;
    int          cut_after;  // rx_valid forced low from this beat on, -1 for never
    bit          hold_start;
    int unsigned exp_err;
    int unsigned exp_rx;
    bit          exp_to;
    bit          exp_pass;
    int unsigned exp_done_edge;  // 0: derive from last rx edge
  } scen_t;

  scen_t tbl[5];

  int unsigned total = 0;
  int unsigned bad = 0;

  scen_t      cur;
  logic [7:0] fifo[$];
  int         tx_idx, rx_idx, model_err;
  int         edge_no, last_rx_edge;
  logic       prev_stall;
  logic [7:0] prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, " tx_valid"}, 32'(tx_valid), 0);
    chk({tag, " tx_data"}, 32'(tx_data), 32'(SEED));
    chk({tag, " rx_ready"}, 32'(rx_ready), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " pass"}, 32'(pass), 0);
    chk({tag, " timeout"}, 32'(timeout), 0);
    chk({tag, " err_count"}, 32'(err_count), 0);
    chk({tag, " rx_count"}, 32'(rx_count), 0);
  endtask

  task automatic clear_model();
    fifo.delete();
    tx_idx = 0;
    rx_idx = 0;
    model_err = 0;
    edge_no = 0;
    last_rx_edge = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
  endtask

  // One loopback cycle: drive at negedge, account handshakes at posedge, check counters after.
  task automatic cycle();
    logic       txh, rxh;
    logic [7:0] rbyte, td, exp_b;
    @(negedge sys_clk);
    if (cur.direct) begin
      tx_ready = rx_ready;
      rx_valid = tx_valid;
      rbyte    = tx_data;
    end else begin
      tx_ready = ($urandom_range(99) >= cur.tx_stall);
      rx_valid = (fifo.size() > 0) && !(cur.cut_after >= 0 && rx_idx >= cur.cut_after)
                 && ($urandom_range(99) >= cur.rx_stall);
      rbyte    = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
    if (rx_idx == cur.corrupt_a || rx_idx == cur.corrupt_b) rbyte = rbyte ^ 8'h01;
    rx_data = rbyte;
    #1;
    txh = tx_valid & tx_ready;
    rxh = rx_valid & rx_ready;
    td  = tx_data;
    chk("tx_valid pattern", 32'(tx_valid), 32'(tx_idx < int'(BURST_LEN)));
    if (tx_valid) begin
      exp_b = SEED + tx_idx[7:0];
      chk("tx_data pattern", 32'(tx_data), 32'(exp_b));
    end
    if (prev_stall) chk("tx hold during stall", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
    prev_stall = tx_valid & ~tx_ready;
    prev_data  = tx_data;
    @(posedge sys_clk);
    edge_no++;
    if (txh) begin
      if (!cur.direct) fifo.push_back(td);
      tx_idx++;
    end
    if (rxh) begin
      if (!cur.direct) void'(fifo.pop_front());
      exp_b = SEED + rx_idx[7:0];
      if (rbyte != exp_b) model_err++;
      rx_idx++;
      last_rx_edge = edge_no;
    end
    #1;
    chk("rx_count track", 32'(rx_count), 32'(rx_idx));
    chk("err_count track", 32'(err_count), 32'(model_err));
  endtask

  task automatic run(input int s);
    int n;
    int unsigned exp_edge;
    int unsigned held;
    cur = tbl[s];
    clear_model();
    @(negedge sys_clk);
    start    = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    @(posedge sys_clk);
    #1;
    chk("busy after start", 32'(busy), 1);
    chk("tx_valid after start", 32'(tx_valid), 1);
    chk("rx_count cleared", 32'(rx_count), 0);
    chk("err_count cleared", 32'(err_count), 0);
    chk("timeout cleared", 32'(timeout), 0);
    if (!cur.hold_start) start = 1'b0;
    n = 0;
    while (!done && n < int'(BUDGET)) begin
      cycle();
      n++;
    end
    chk("done within budget", 32'(done), 1);
    if (!done) return;
    exp_edge = (cur.exp_done_edge != 0) ? cur.exp_done_edge :
               (cur.exp_to ? 32'(last_rx_edge) + TIMEOUT : 32'(last_rx_edge));
    chk("done edge", 32'(edge_no), exp_edge);
    chk("final pass", 32'(pass), 32'(cur.exp_pass));
    chk("final timeout", 32'(timeout), 32'(cur.exp_to));
    chk("final err_count", 32'(err_count), cur.exp_err);
    chk("final rx_count", 32'(rx_count), cur.exp_rx);
    chk("busy low in done", 32'(busy), 0);
    chk("rx_ready low in done", 32'(rx_ready), 0);
    chk("tx_valid low in done", 32'(tx_valid), 0);
    if (!cur.exp_to) chk("all beats sent", 32'(tx_idx), BURST_LEN);
    if (!cur.hold_start) begin
      // Traffic offered in DONE must be ignored.
      held = 32'(rx_count);
      @(negedge sys_clk);
      rx_valid = 1'b1;
      tx_ready = 1'b1;
      rx_data  = 8'h5A;
      repeat (3) @(posedge sys_clk);
      #1;
      chk("rx ignored in done", 32'(rx_count), held);
      chk("done holds", 32'(done), 1);
      rx_valid = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{direct: 1'b1, tx_stall: 0, rx_stall: 0, corrupt_a: -1, corrupt_b: -1,
               cut_after: -1, hold_start: 1'b0, exp_err: 0, exp_rx: BURST_LEN, exp_to: 1'b0,
               exp_pass: 1'b1, exp_done_edge: BURST_LEN};
    tbl[1] = '{direct: 1'b0, tx_stall: 50, rx_stall: 50, corrupt_a: -1, corrupt_b: -1,
               cut_after: -1, hold_start: 1'b0, exp_err: 0, exp_rx: BURST_LEN, exp_to: 1'b0,
               exp_pass: 1'b1, exp_done_edge: 0};
    tbl[2] = '{direct: 1'b0, tx_stall: 20, rx_stall: 20, corrupt_a: 5, corrupt_b: 9,
               cut_after: -1, hold_start: 1'b0, exp_err: 2, exp_rx: BURST_LEN, exp_to: 1'b0,
               exp_pass: 1'b0, exp_done_edge: 0};
    tbl[3] = '{direct: 1'b0, tx_stall: 0, rx_stall: 0, corrupt_a: -1, corrupt_b: -1,
               cut_after: 10, hold_start: 1'b0, exp_err: 0, exp_rx: 10, exp_to: 1'b1,
               exp_pass: 1'b0, exp_done_edge: 0};
    tbl[4] = '{direct: 1'b1, tx_stall: 0, rx_stall: 0, corrupt_a: -1, corrupt_b: -1,
               cut_after: -1, hold_start: 1'b1, exp_err: 0, exp_rx: BURST_LEN, exp_to: 1'b0,
               exp_pass: 1'b1, exp_done_edge: BURST_LEN};

    #2;
    reset_check("por");
    #20;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("idle without start", 32'(busy), 0);

    for (int s = 0; s < 5; s++) run(s);

    // start still high from the held run: the next edge in DONE restarts with cleared counters.
    @(posedge sys_clk);
    #1;
    chk("restart busy", 32'(busy), 1);
    chk("restart done", 32'(done), 0);
    chk("restart rx_count", 32'(rx_count), 0);
    chk("restart err_count", 32'(err_count), 0);
    start = 1'b0;
    clear_model();
    repeat (20) cycle();
    chk("mid-run progress", 32'(rx_count > 16'd0), 1);

    // Asynchronous reset between clock edges.
    #2;
    sys_rst_n = 1'b0;
    #1;
    reset_check("async rst");
    repeat (2) @(posedge sys_clk);
    #1;
    reset_check("held rst");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;

    run(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
